// File: rtl/mem_lsu.sv
// ============================================================================
// Module   : mem_lsu
// Brief    : Single-outstanding load/store unit in front of a word-addressed,
//            byte-masked data memory, with saturating debug counters.
// Revision : 1.0
// ============================================================================
`default_nettype none

module mem_lsu #(
   parameter int CNT_W = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             req_valid,
   output logic             req_ready,
   input  logic             req_we,
   input  logic [2:0]       req_funct3,
   input  logic [31:0]      req_addr,
   input  logic [31:0]      req_wdata,
   output logic             resp_valid,
   input  logic             resp_ready,
   output logic [31:0]      resp_rdata,
   output logic             resp_fault,
   output logic             dmem_we,
   output logic [3:0]       dmem_wmask,
   output logic [29:0]      dmem_addr,
   output logic [31:0]      dmem_wd,
   input  logic [31:0]      dmem_rd,
   output logic [CNT_W-1:0] load_cnt,
   output logic [CNT_W-1:0] store_cnt,
   output logic [CNT_W-1:0] fault_cnt
);

   typedef enum logic [1:0] {
      S_IDLE   = 2'd0,
      S_ACCESS = 2'd1,
      S_RESP   = 2'd2
   } state_t;

   state_t      r_state;
   logic        r_we;
   logic        r_fault;
   logic [2:0]  r_funct3;
   logic [31:0] r_addr;
   logic [3:0]  r_mask;
   logic [31:0] r_wd;
   logic [31:0] r_rdata;
   logic        r_resp_fault;

   logic        w_fault;
   logic [3:0]  w_mask;
   logic [31:0] w_wd;
   logic [31:0] w_shift;
   logic [31:0] w_load;
   logic        w_do_store;

   // Request-side decode, evaluated on the live inputs and latched at accept.
   always_comb begin
      w_fault = 1'b1;
      if (req_we) begin
         case (req_funct3)
            3'b000:  w_fault = 1'b0;
            3'b001:  w_fault = req_addr[0];
            3'b010:  w_fault = (req_addr[1:0] != 2'b00);
            default: w_fault = 1'b1;
         endcase
      end else begin
         case (req_funct3)
            3'b000, 3'b100: w_fault = 1'b0;
            3'b001, 3'b101: w_fault = req_addr[0];
            3'b010:         w_fault = (req_addr[1:0] != 2'b00);
            default:        w_fault = 1'b1;
         endcase
      end
   end

   always_comb begin
      w_mask = 4'b1111;
      w_wd   = req_wdata;
      case (req_funct3[1:0])
         2'b00: begin
            w_mask = 4'b0001 << req_addr[1:0];
            w_wd   = {4{req_wdata[7:0]}};
         end
         2'b01: begin
            w_mask = 4'b0011 << req_addr[1:0];
            w_wd   = {2{req_wdata[15:0]}};
         end
         default: begin
            w_mask = 4'b1111;
            w_wd   = req_wdata;
         end
      endcase
   end

   // Lane-align the read word so the addressed byte/half sits at bit 0.
   assign w_shift = dmem_rd >> {r_addr[1:0], 3'b000};

   always_comb begin
      w_load = 32'h0;
      case (r_funct3)
         3'b000:  w_load = {{24{w_shift[7]}}, w_shift[7:0]};
         3'b100:  w_load = {24'h0, w_shift[7:0]};
         3'b001:  w_load = {{16{w_shift[15]}}, w_shift[15:0]};
         3'b101:  w_load = {16'h0, w_shift[15:0]};
         3'b010:  w_load = w_shift;
         default: w_load = 32'h0;
      endcase
   end

   // Write strobes come straight from state so an async reset kills them at once.
   assign w_do_store = (r_state == S_ACCESS) && r_we && !r_fault;
   assign dmem_we    = w_do_store;
   assign dmem_wmask = w_do_store ? r_mask : 4'b0000;
   assign dmem_addr  = r_addr[31:2];
   assign dmem_wd    = r_wd;
   assign req_ready  = (r_state == S_IDLE);
   assign resp_valid = (r_state == S_RESP);
   assign resp_rdata = r_rdata;
   assign resp_fault = r_resp_fault;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_state      <= S_IDLE;
         r_we         <= 1'b0;
         r_fault      <= 1'b0;
         r_funct3     <= 3'b000;
         r_addr       <= 32'h0;
         r_mask       <= 4'b0000;
         r_wd         <= 32'h0;
         r_rdata      <= 32'h0;
         r_resp_fault <= 1'b0;
         load_cnt     <= '0;
         store_cnt    <= '0;
         fault_cnt    <= '0;
      end else begin
         case (r_state)
            S_IDLE: begin
               if (req_valid) begin
                  r_we     <= req_we;
                  r_fault  <= w_fault;
                  r_funct3 <= req_funct3;
                  r_addr   <= req_addr;
                  r_mask   <= w_mask;
                  r_wd     <= w_wd;
                  r_state  <= S_ACCESS;
               end
            end
            S_ACCESS: begin
               r_rdata      <= (r_we || r_fault) ? 32'h0 : w_load;
               r_resp_fault <= r_fault;
               if (r_fault) begin
                  if (fault_cnt != {CNT_W{1'b1}}) fault_cnt <= fault_cnt + 1'b1;
               end else if (r_we) begin
                  if (store_cnt != {CNT_W{1'b1}}) store_cnt <= store_cnt + 1'b1;
               end else begin
                  if (load_cnt != {CNT_W{1'b1}}) load_cnt <= load_cnt + 1'b1;
               end
               r_state <= S_RESP;
            end
            S_RESP: begin
               if (resp_ready) r_state <= S_IDLE;
            end
            default: r_state <= S_IDLE;
         endcase
      end
   end

endmodule

`default_nettype wire

// File: tb/tb_mem_lsu.sv
// ============================================================================
// Module   : tb_mem_lsu
// Brief    : Directed self-checking bench for mem_lsu with a small memory model.
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_mem_lsu;

   logic        clk;
   logic        rst;
   logic        req_valid;
   logic        req_ready;
   logic        req_we;
   logic [2:0]  req_funct3;
   logic [31:0] req_addr;
   logic [31:0] req_wdata;
   logic        resp_valid;
   logic        resp_ready;
   logic [31:0] resp_rdata;
   logic        resp_fault;
   logic        dmem_we;
   logic [3:0]  dmem_wmask;
   logic [29:0] dmem_addr;
   logic [31:0] dmem_wd;
   logic [31:0] dmem_rd;
   logic [15:0] load_cnt;
   logic [15:0] store_cnt;
   logic [15:0] fault_cnt;

   int checks = 0;
   int errors = 0;

   logic [31:0] mem [0:63];

   mem_lsu #(.CNT_W(16)) dut (
      .clk(clk), .rst(rst),
      .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
      .req_funct3(req_funct3), .req_addr(req_addr), .req_wdata(req_wdata),
      .resp_valid(resp_valid), .resp_ready(resp_ready),
      .resp_rdata(resp_rdata), .resp_fault(resp_fault),
      .dmem_we(dmem_we), .dmem_wmask(dmem_wmask), .dmem_addr(dmem_addr),
      .dmem_wd(dmem_wd), .dmem_rd(dmem_rd),
      .load_cnt(load_cnt), .store_cnt(store_cnt), .fault_cnt(fault_cnt)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   assign dmem_rd = mem[dmem_addr[5:0]];

   always @(posedge clk) begin
      if (dmem_we) begin
         for (int b = 0; b < 4; b++)
            if (dmem_wmask[b]) mem[dmem_addr[5:0]][8*b +: 8] <= dmem_wd[8*b +: 8];
      end
   end

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got=%h exp=%h", tag, got, exp);
      end
   endtask

   // One request with resp_ready high; request fields are scrambled after accept.
   task automatic do_req(input logic we, input logic [2:0] f3, input logic [31:0] a,
                         input logic [31:0] wd, input logic exp_fault,
                         input logic [31:0] exp_rd, input logic [3:0] exp_mask,
                         input logic [31:0] exp_wd);
      @(negedge clk);
      req_valid  = 1'b1;
      req_we     = we;
      req_funct3 = f3;
      req_addr   = a;
      req_wdata  = wd;
      @(negedge clk);
      req_valid  = 1'b0;
      req_addr   = 32'h0000_0000;
      req_wdata  = 32'hDEAD_BEEF;
      req_funct3 = 3'b111;
      chk("acc_ready", {31'h0, req_ready}, 32'h0);
      chk("acc_we", {31'h0, dmem_we}, {31'h0, we & ~exp_fault});
      chk("acc_mask", {28'h0, dmem_wmask}, {28'h0, exp_mask});
      chk("acc_addr", {2'b00, dmem_addr}, {2'b00, a[31:2]});
      if (we && !exp_fault) chk("acc_wd", dmem_wd, exp_wd);
      @(negedge clk);
      chk("resp_valid", {31'h0, resp_valid}, 32'h1);
      chk("resp_rdata", resp_rdata, exp_rd);
      chk("resp_fault", {31'h0, resp_fault}, {31'h0, exp_fault});
      @(negedge clk);
      chk("idle_ready", {31'h0, req_ready}, 32'h1);
      chk("idle_valid", {31'h0, resp_valid}, 32'h0);
   endtask

   logic [31:0] held;

   initial begin
      for (int i = 0; i < 64; i++) mem[i] = 32'h0;
      rst        = 1'b0;
      req_valid  = 1'b0;
      req_we     = 1'b0;
      req_funct3 = 3'b000;
      req_addr   = 32'h0;
      req_wdata  = 32'h0;
      resp_ready = 1'b1;
      repeat (3) @(negedge clk);

      chk("rst_ready", {31'h0, req_ready}, 32'h1);
      chk("rst_valid", {31'h0, resp_valid}, 32'h0);
      chk("rst_rdata", resp_rdata, 32'h0);
      chk("rst_fault", {31'h0, resp_fault}, 32'h0);
      chk("rst_we", {31'h0, dmem_we}, 32'h0);
      chk("rst_mask", {28'h0, dmem_wmask}, 32'h0);
      chk("rst_addr", {2'b00, dmem_addr}, 32'h0);
      chk("rst_wd", dmem_wd, 32'h0);
      chk("rst_cnt", {load_cnt, store_cnt}, 32'h0);
      chk("rst_fcnt", {16'h0, fault_cnt}, 32'h0);
      rst = 1'b1;

      // Word store then full-word load back
      do_req(1'b1, 3'b010, 32'h64, 32'h8475_5779, 1'b0, 32'h0, 4'b1111, 32'h8475_5779);
      do_req(1'b0, 3'b010, 32'h64, 32'h0, 1'b0, 32'h8475_5779, 4'b0000, 32'h0);
      chk("cnt_st1", {16'h0, store_cnt}, 32'd1);
      chk("cnt_ld1", {16'h0, load_cnt}, 32'd1);

      // Sub-word loads with sign/zero extension
      do_req(1'b0, 3'b000, 32'h67, 32'h0, 1'b0, 32'hFFFF_FF84, 4'b0000, 32'h0);
      do_req(1'b0, 3'b100, 32'h67, 32'h0, 1'b0, 32'h0000_0084, 4'b0000, 32'h0);
      do_req(1'b0, 3'b001, 32'h66, 32'h0, 1'b0, 32'hFFFF_8475, 4'b0000, 32'h0);
      do_req(1'b0, 3'b101, 32'h64, 32'h0, 1'b0, 32'h0000_5779, 4'b0000, 32'h0);

      // Byte and half stores into upper lanes
      do_req(1'b1, 3'b000, 32'h65, 32'h0000_00AB, 1'b0, 32'h0, 4'b0010, 32'hABAB_ABAB);
      do_req(1'b0, 3'b010, 32'h64, 32'h0, 1'b0, 32'h8475_AB79, 4'b0000, 32'h0);
      do_req(1'b1, 3'b001, 32'h66, 32'hFFFF_1234, 1'b0, 32'h0, 4'b1100, 32'h1234_1234);
      do_req(1'b0, 3'b010, 32'h64, 32'h0, 1'b0, 32'h1234_AB79, 4'b0000, 32'h0);

      // Faults: misaligned word load, misaligned half store, illegal load funct3
      do_req(1'b0, 3'b010, 32'h62, 32'h0, 1'b1, 32'h0, 4'b0000, 32'h0);
      do_req(1'b1, 3'b001, 32'h61, 32'h5555_5555, 1'b1, 32'h0, 4'b0000, 32'h0);
      do_req(1'b0, 3'b011, 32'h64, 32'h0, 1'b1, 32'h0, 4'b0000, 32'h0);
      chk("cnt_fault", {16'h0, fault_cnt}, 32'd3);
      chk("mem_unch", mem[24], 32'h0);
      chk("mem_word", mem[25], 32'h1234_AB79);
      do_req(1'b0, 3'b010, 32'h64, 32'h0, 1'b0, 32'h1234_AB79, 4'b0000, 32'h0);
      chk("cnt_ld8", {16'h0, load_cnt}, 32'd8);
      chk("cnt_st3", {16'h0, store_cnt}, 32'd3);

      // Back-pressure on the response channel
      resp_ready = 1'b0;
      @(negedge clk);
      req_valid = 1'b1; req_we = 1'b0; req_funct3 = 3'b010; req_addr = 32'h64;
      @(negedge clk);
      req_valid = 1'b0;
      @(negedge clk);
      held = 32'h1234_AB79;
      for (int i = 0; i < 5; i++) begin
         chk("bp_valid", {31'h0, resp_valid}, 32'h1);
         chk("bp_rdata", resp_rdata, held);
         chk("bp_ready", {31'h0, req_ready}, 32'h0);
         chk("bp_we", {31'h0, dmem_we}, 32'h0);
         if (i == 1) begin
            req_valid = 1'b1; req_we = 1'b1; req_funct3 = 3'b010;
            req_addr = 32'h0; req_wdata = 32'h5555_5555;
         end
         @(negedge clk);
      end
      req_valid  = 1'b0;
      resp_ready = 1'b1;
      @(negedge clk);
      chk("bp_done_ready", {31'h0, req_ready}, 32'h1);
      chk("bp_done_valid", {31'h0, resp_valid}, 32'h0);
      chk("bp_ld_cnt", {16'h0, load_cnt}, 32'd9);
      chk("bp_no_store", mem[0], 32'h0);

      // Asynchronous reset in the middle of a store's ACCESS cycle
      req_valid = 1'b1; req_we = 1'b1; req_funct3 = 3'b010;
      req_addr = 32'h0; req_wdata = 32'hFFFF_FFFF;
      @(negedge clk);
      req_valid = 1'b0;
      chk("ar_we_pre", {31'h0, dmem_we}, 32'h1);
      #2 rst = 1'b0;
      #1;
      chk("ar_we_drop", {31'h0, dmem_we}, 32'h0);
      chk("ar_mask", {28'h0, dmem_wmask}, 32'h0);
      chk("ar_ready", {31'h0, req_ready}, 32'h1);
      @(posedge clk);
      #1;
      chk("ar_mem0", mem[0], 32'h0);
      chk("ar_valid", {31'h0, resp_valid}, 32'h0);
      chk("ar_rdata", resp_rdata, 32'h0);
      chk("ar_fault", {31'h0, resp_fault}, 32'h0);
      chk("ar_addr", {2'b00, dmem_addr}, 32'h0);
      chk("ar_wd", dmem_wd, 32'h0);
      chk("ar_cnt", {load_cnt, store_cnt}, 32'h0);
      chk("ar_fcnt", {16'h0, fault_cnt}, 32'h0);
      @(negedge clk);
      rst = 1'b1;
      do_req(1'b0, 3'b010, 32'h0, 32'h0, 1'b0, 32'h0, 4'b0000, 32'h0);
      chk("post_ld_cnt", {16'h0, load_cnt}, 32'd1);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

`default_nettype wire
